branch_redirect_ctrl: RTL

Branch resolution and front-end redirect controller for the pipelined RV32 core. It consumes the EX-stage branch condition (`Cnd`) plus the prediction that travelled with the instruction. It owns a 2-bit bimodal history table queried by fetch. On a mispredict it sequences the recovery: record the outcome, flush IF/ID, stall EX, and hold a redirect to fetch until fetch accepts it.

---
 rtl/branch_redirect_ctrl_pkg.sv | 25 ++
 rtl/branch_redirect_ctrl_if.sv | 36 +++
 rtl/branch_redirect_ctrl_bht_2bit.sv | 33 +++
 rtl/branch_redirect_ctrl.sv | 92 +++++++++
 4 files changed

// File: rtl/branch_redirect_ctrl_pkg.sv
// rtl/branch_redirect_ctrl_pkg.sv - shared FSM states, counter encodings and update helper
package branch_redirect_ctrl_pkg;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_REDIRECT = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_t;

  localparam logic [1:0] BHT_INIT = CTR_WNT;

  function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
    if (taken) begin
      return (ctr == CTR_ST) ? ctr : ctr + 2'd1;
    end
    return (ctr == CTR_SNT) ? ctr : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/branch_redirect_ctrl_if.sv
// rtl/branch_redirect_ctrl_if.sv - EX resolution, fetch lookup/redirect and counter signals
interface branch_redirect_ctrl_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic            ex_valid;
  logic            ex_branch;
  logic            ex_jump;
  logic            ex_cnd;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_target;
  logic            ex_pred_taken;
  logic [XLEN-1:0] if_pc;
  logic            pred_taken;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            redirect_ready;
  logic            flush;
  logic            ex_stall;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispredict_cnt;

  modport master (
    output ex_valid, ex_branch, ex_jump, ex_cnd, ex_pc, ex_target, ex_pred_taken,
    output if_pc, redirect_ready,
    input  pred_taken, redirect_valid, redirect_pc, flush, ex_stall,
    input  branch_cnt, mispredict_cnt
  );

  modport slave (
    input  ex_valid, ex_branch, ex_jump, ex_cnd, ex_pc, ex_target, ex_pred_taken,
    input  if_pc, redirect_ready,
    output pred_taken, redirect_valid, redirect_pc, flush, ex_stall,
    output branch_cnt, mispredict_cnt
  );
endinterface

// File: rtl/branch_redirect_ctrl_bht_2bit.sv
// rtl/branch_redirect_ctrl_bht_2bit.sv - bimodal table of 2-bit saturating counters
module bht_2bit
  import branch_redirect_ctrl_pkg::*;
#(
  parameter int BHT_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BHT_BITS-1:0] rd_idx_i,
  output logic                rd_taken_o,
  input  logic                wr_en_i,
  input  logic [BHT_BITS-1:0] wr_idx_i,
  input  logic                wr_taken_i
);
  localparam int ENTRIES = 1 << BHT_BITS;

  logic [1:0] table_q [ENTRIES];
  logic [1:0] wr_ctr_d;

  // Read port sees the pre-update value on a same-index write.
  assign rd_taken_o = table_q[rd_idx_i][1];
  assign wr_ctr_d   = ctr_update(table_q[wr_idx_i], wr_taken_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_q[i] <= BHT_INIT;
      end
    end else if (wr_en_i) begin
      table_q[wr_idx_i] <= wr_ctr_d;
    end
  end
endmodule

// File: rtl/branch_redirect_ctrl.sv
// rtl/branch_redirect_ctrl.sv - branch resolution, mispredict recovery FSM and perf counters
module branch_redirect_ctrl
  import branch_redirect_ctrl_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int BHT_BITS = 4,
  parameter int CNT_W    = 32
) (
  input logic                  clk,
  input logic                  rst,
  branch_redirect_ctrl_if.slave bus
);
  state_t           state_q, state_d;
  logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispredict_cnt_q, mispredict_cnt_d;

  logic            taken;
  logic            accept;
  logic            mispredict;
  logic            bht_wr_en;
  logic [XLEN-1:0] next_pc;
  logic            redirect_active;
  logic            unused_if_pc;

  assign taken      = bus.ex_jump | (bus.ex_branch & bus.ex_cnd);
  assign next_pc    = taken ? bus.ex_target : bus.ex_pc + XLEN'(4);
  assign accept     = (state_q == ST_IDLE) & bus.ex_valid & (bus.ex_branch | bus.ex_jump);
  assign mispredict = accept & (taken != bus.ex_pred_taken);
  // Jumps never train the table, even when the branch flag is also set.
  assign bht_wr_en  = accept & bus.ex_branch & ~bus.ex_jump;

  assign unused_if_pc = ^{bus.if_pc[XLEN-1:BHT_BITS+2], bus.if_pc[1:0]};

  bht_2bit #(.BHT_BITS(BHT_BITS)) u_bht (
    .clk        (clk),
    .rst        (rst),
    .rd_idx_i   (bus.if_pc[BHT_BITS+1:2]),
    .rd_taken_o (bus.pred_taken),
    .wr_en_i    (bht_wr_en),
    .wr_idx_i   (bus.ex_pc[BHT_BITS+1:2]),
    .wr_taken_i (taken)
  );

  always_comb begin
    state_d          = state_q;
    redirect_pc_d    = redirect_pc_q;
    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;
    redirect_active  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          branch_cnt_d = branch_cnt_q + CNT_W'(1);
        end
        if (mispredict) begin
          mispredict_cnt_d = mispredict_cnt_q + CNT_W'(1);
          redirect_pc_d    = next_pc;
          state_d          = ST_REDIRECT;
        end
      end
      ST_REDIRECT: begin
        redirect_active = 1'b1;
        if (bus.redirect_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      redirect_pc_q    <= '0;
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      state_q          <= state_d;
      redirect_pc_q    <= redirect_pc_d;
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  assign bus.redirect_valid = redirect_active;
  assign bus.flush          = redirect_active;
  assign bus.ex_stall       = redirect_active;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.branch_cnt     = branch_cnt_q;
  assign bus.mispredict_cnt = mispredict_cnt_q;
endmodule
